// File: rtl/range_tracker_if.sv
// Sample/control bundle for the streaming min/max/range tracker.
// The master side drives framed samples; the slave side is the tracker,
// which returns the running results and the frame status.
interface range_tracker_if #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
  logic [WIDTH-1:0] range_out;
  logic [CNT_W-1:0] count_out;
  logic             busy;
  logic             done;
  logic             error;
  logic             cnt_sat;

  modport master (
    output data_in, valid, go, finish,
    input  min_out, max_out, range_out, count_out, busy, done, error, cnt_sat
  );

  modport slave (
    input  data_in, valid, go, finish,
    output min_out, max_out, range_out, count_out, busy, done, error, cnt_sat
  );
endinterface

// File: rtl/range_tracker.sv
// Streaming min/max/range monitor for framed sample streams.
// A frame opens with go and closes with finish; every accepted sample
// updates the running minimum, maximum and a saturating sample count.
// Results stay on the outputs after the frame closes until a new frame
// seeds them with its first sample. An empty frame lands in ERROR with
// all results cleared.
module range_tracker #(
  parameter int WIDTH  = 10,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic            clock,
  input  logic            reset,
  range_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [CNT_W-1:0] count_q;
  logic             cnt_sat_q;

  // Datapath controls produced by the next-state block.
  logic start_frame;
  logic accept_sample;
  logic clear_results;

  // Magnitude comparisons of the incoming sample against the running extremes.
  logic less_than_min;
  logic greater_than_max;

  // Compare the sample against the current extremes, honouring signedness.
  always_comb begin
    less_than_min    = 1'b0;
    greater_than_max = 1'b0;
    if (SIGNED != 0) begin
      less_than_min    = $signed(bus.data_in) < $signed(min_q);
      greater_than_max = $signed(bus.data_in) > $signed(max_q);
    end else begin
      less_than_min    = bus.data_in < min_q;
      greater_than_max = bus.data_in > max_q;
    end
  end

  // Frame state register; reset returns straight to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the strobes that steer the result registers.
  // finish always dominates go, and go is ignored while a frame is running.
  always_comb begin
    state_d       = state_q;
    start_frame   = 1'b0;
    accept_sample = 1'b0;
    clear_results = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.finish) begin
          state_d       = S_ERROR;
          clear_results = 1'b1;
        end else if (bus.go) begin
          state_d     = S_RUN;
          start_frame = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.finish) begin
          if (count_q != '0) begin
            state_d = S_DONE;
          end else begin
            state_d       = S_ERROR;
            clear_results = 1'b1;
          end
        end else if (bus.valid) begin
          accept_sample = 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.finish) begin
          if (bus.go) begin
            state_d     = S_RUN;
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        if (bus.go && !bus.finish) begin
          state_d     = S_RUN;
          start_frame = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result registers: cleared on an empty/misused frame, seeded by the first
  // sample of a frame, then narrowed/widened by later samples. The counter
  // holds at all-ones and flags saturation when a sample arrives while full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q     <= '0;
      max_q     <= '0;
      count_q   <= '0;
      cnt_sat_q <= 1'b0;
    end else if (clear_results) begin
      min_q     <= '0;
      max_q     <= '0;
      count_q   <= '0;
      cnt_sat_q <= 1'b0;
    end else if (start_frame) begin
      cnt_sat_q <= 1'b0;
      if (bus.valid) begin
        min_q   <= bus.data_in;
        max_q   <= bus.data_in;
        count_q <= CNT_W'(1);
      end else begin
        count_q <= '0;
      end
    end else if (accept_sample) begin
      if (count_q == '0) begin
        min_q <= bus.data_in;
        max_q <= bus.data_in;
      end else begin
        if (less_than_min) begin
          min_q <= bus.data_in;
        end
        if (greater_than_max) begin
          max_q <= bus.data_in;
        end
      end
      if (count_q == CNT_MAX) begin
        cnt_sat_q <= 1'b1;
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registers; range wraps modulo 2^WIDTH so it
  // is non-negative in both comparison modes.
  assign bus.min_out   = min_q;
  assign bus.max_out   = max_q;
  assign bus.range_out = max_q - min_q;
  assign bus.count_out = count_q;
  assign bus.cnt_sat   = cnt_sat_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_range_tracker.sv
// Scoreboard bench for range_tracker: three instances (unsigned, signed and
// a 3-bit counter) share one input stream. A frame-level reference model
// keeps the list of accepted samples and derives the expected results from
// it; expectations are queued per instance and a monitor pops and compares
// them a little after each rising edge.
module tb_range_tracker;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         valid;
  logic         go;
  logic         finish;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  range_tracker_if #(.WIDTH(W), .CNT_W(8)) bus_u ();
  range_tracker_if #(.WIDTH(W), .CNT_W(8)) bus_s ();
  range_tracker_if #(.WIDTH(W), .CNT_W(3)) bus_c ();

  assign bus_u.data_in = data_in;
  assign bus_u.valid   = valid;
  assign bus_u.go      = go;
  assign bus_u.finish  = finish;
  assign bus_s.data_in = data_in;
  assign bus_s.valid   = valid;
  assign bus_s.go      = go;
  assign bus_s.finish  = finish;
  assign bus_c.data_in = data_in;
  assign bus_c.valid   = valid;
  assign bus_c.go      = go;
  assign bus_c.finish  = finish;

  range_tracker #(.WIDTH(W), .CNT_W(8), .SIGNED(0)) dut_u (.clock(clock), .reset(reset), .bus(bus_u.slave));
  range_tracker #(.WIDTH(W), .CNT_W(8), .SIGNED(1)) dut_s (.clock(clock), .reset(reset), .bus(bus_s.slave));
  range_tracker #(.WIDTH(W), .CNT_W(3), .SIGNED(0)) dut_c (.clock(clock), .reset(reset), .bus(bus_c.slave));

  typedef struct {
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    logic [W-1:0] rg;
    int           cnt;
    logic         busy;
    logic         done;
    logic         err;
    logic         sat;
  } exp_t;

  exp_t qu[$];
  exp_t qs[$];
  exp_t qc[$];

  // Reference model: frame phase, accepted samples of the current frame and
  // the extremes currently on display (held between frames).
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERROR} phase_t;
  phase_t phase;
  int     samples[$];
  int     u_min, u_max, s_min, s_max;

  function automatic int as_signed(input int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  task automatic model_clear();
    samples.delete();
    u_min = 0; u_max = 0; s_min = 0; s_max = 0;
  endtask

  task automatic model_accept(input int d);
    samples.push_back(d);
    u_min = samples[0]; u_max = samples[0];
    s_min = as_signed(samples[0]); s_max = as_signed(samples[0]);
    foreach (samples[i]) begin
      if (samples[i] < u_min) u_min = samples[i];
      if (samples[i] > u_max) u_max = samples[i];
      if (as_signed(samples[i]) < s_min) s_min = as_signed(samples[i]);
      if (as_signed(samples[i]) > s_max) s_max = as_signed(samples[i]);
    end
  endtask

  task automatic model_start(input bit v, input int d);
    phase = M_RUN;
    samples.delete();
    if (v) model_accept(d);
  endtask

  task automatic model_step(input bit g, input bit f, input bit v, input int d);
    case (phase)
      M_IDLE: begin
        if (f) begin phase = M_ERROR; model_clear(); end
        else if (g) model_start(v, d);
      end
      M_RUN: begin
        if (f) begin
          if (samples.size() > 0) phase = M_DONE;
          else begin phase = M_ERROR; model_clear(); end
        end else if (v) model_accept(d);
      end
      M_DONE: begin
        if (!f) begin
          if (g) model_start(v, d);
          else phase = M_IDLE;
        end
      end
      M_ERROR: begin
        if (g && !f) model_start(v, d);
      end
      default: phase = M_IDLE;
    endcase
  endtask

  function automatic exp_t make_exp(input bit sgn, input int cntw);
    exp_t e;
    int   mn, mx, maxc;
    maxc   = (1 << cntw) - 1;
    mn     = sgn ? s_min : u_min;
    mx     = sgn ? s_max : u_max;
    e.mn   = W'(mn & 1023);
    e.mx   = W'(mx & 1023);
    e.rg   = W'((mx - mn) & 1023);
    e.cnt  = (samples.size() > maxc) ? maxc : samples.size();
    e.sat  = (samples.size() > maxc);
    e.busy = (phase == M_RUN);
    e.done = (phase == M_DONE);
    e.err  = (phase == M_ERROR);
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mx,
                             input logic [W-1:0] rg, input logic [31:0] cnt, input logic b,
                             input logic d, input logic e, input logic s, input exp_t x);
    cmp({tag, ".min"},   32'(mn), 32'(x.mn));
    cmp({tag, ".max"},   32'(mx), 32'(x.mx));
    cmp({tag, ".range"}, 32'(rg), 32'(x.rg));
    cmp({tag, ".count"}, cnt,     32'(x.cnt));
    cmp({tag, ".busy"},  32'(b),  32'(x.busy));
    cmp({tag, ".done"},  32'(d),  32'(x.done));
    cmp({tag, ".error"}, 32'(e),  32'(x.err));
    cmp({tag, ".sat"},   32'(s),  32'(x.sat));
  endtask

  // Drive one cycle of inputs and queue what each instance must show after
  // the next rising edge.
  task automatic applyStimulus(input bit g, input bit f, input bit v, input int d);
    @(negedge clock);
    go = g; finish = f; valid = v; data_in = W'(d);
    model_step(g, f, v, d);
    qu.push_back(make_exp(1'b0, 8));
    qs.push_back(make_exp(1'b1, 8));
    qc.push_back(make_exp(1'b0, 3));
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, ".u.min"},   32'(bus_u.min_out), 0);
    cmp({tag, ".u.max"},   32'(bus_u.max_out), 0);
    cmp({tag, ".u.count"}, 32'(bus_u.count_out), 0);
    cmp({tag, ".u.busy"},  32'(bus_u.busy), 0);
    cmp({tag, ".s.range"}, 32'(bus_s.range_out), 0);
    cmp({tag, ".s.busy"},  32'(bus_s.busy), 0);
    cmp({tag, ".c.count"}, 32'(bus_c.count_out), 0);
    cmp({tag, ".c.sat"},   32'(bus_c.cnt_sat), 0);
    cmp({tag, ".c.error"}, 32'(bus_c.error), 0);
    cmp({tag, ".c.done"},  32'(bus_c.done), 0);
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock.
  task automatic applyReset(input string tag);
    @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    phase = M_IDLE;
    model_clear();
    @(negedge clock);
    go = 1'b0; finish = 1'b0; valid = 1'b0; data_in = '0;
    reset = 1'b0;
  endtask

  // Monitor: compare the oldest queued expectation shortly after each edge.
  always @(posedge clock) begin
    #2;
    if (qu.size() > 0) begin
      checkOutput("u", bus_u.min_out, bus_u.max_out, bus_u.range_out, 32'(bus_u.count_out),
                  bus_u.busy, bus_u.done, bus_u.error, bus_u.cnt_sat, qu.pop_front());
    end
    if (qs.size() > 0) begin
      checkOutput("s", bus_s.min_out, bus_s.max_out, bus_s.range_out, 32'(bus_s.count_out),
                  bus_s.busy, bus_s.done, bus_s.error, bus_s.cnt_sat, qs.pop_front());
    end
    if (qc.size() > 0) begin
      checkOutput("c", bus_c.min_out, bus_c.max_out, bus_c.range_out, 32'(bus_c.count_out),
                  bus_c.busy, bus_c.done, bus_c.error, bus_c.cnt_sat, qc.pop_front());
    end
  end

  initial begin
    reset = 1'b1; go = 1'b0; finish = 1'b0; valid = 1'b0; data_in = '0;
    phase = M_IDLE;
    model_clear();
    #2;
    check_all_zero("por");
    @(negedge clock);
    reset = 1'b0;

    // Unsigned basic frame, then drop finish into IDLE with results held.
    applyStimulus(1, 0, 1, 300);
    applyStimulus(0, 0, 1, 512);
    applyStimulus(0, 0, 1, 7);
    applyStimulus(0, 0, 1, 1023);
    applyStimulus(0, 0, 1, 100);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // First-sample seeding and valid gating.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 50);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 60);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Signed extremes; go in RUN is ignored and go+finish closes the frame.
    applyStimulus(1, 0, 1, 10'h200);
    applyStimulus(1, 0, 1, 511);
    applyStimulus(0, 0, 1, 1023);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 0, 1, 20);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Empty frame into ERROR, then recovery with a sample.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 9);
    applyStimulus(1, 0, 1, 5);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // IDLE misuse: finish, then go+finish stays in ERROR, then go alone.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 1, 44);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 33);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Nine samples saturate the 3-bit counter, then reset mid-frame.
    applyStimulus(1, 0, 1, 400);
    for (int i = 1; i < 9; i++) applyStimulus(0, 0, 1, 400 + 13 * i);
    applyReset("rst_mid");
    applyStimulus(0, 0, 0, 0);

    // Randomised framing and samples, with one reset part way through.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) applyReset("rst_rand");
      applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 65, int'($urandom_range(0, 1023)));
    end

    applyStimulus(0, 0, 0, 0);
    repeat (3) @(negedge clock);
    cmp("queue_drain", 32'(qu.size() + qs.size() + qc.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/range_tracker.md
Name: range_tracker

Overview:
- Parametrised streaming min/max/range monitor for framed sample streams.
- A frame opens with go and closes with finish. Each accepted sample updates running minimum, maximum, range and sample count.
- Results are held after the frame closes, until the next frame opens.
- Next-generation tracker:
  - width and signedness are configurable;
  - a valid qualifier gates samples;
  - the first sample seeds min/max;
  - empty frames are detected;
  - a saturating sample counter is provided.

Parameters:
- WIDTH, 10, sample width in bits.
- CNT_W, 8, sample-counter width in bits.
- SIGNED, 0, comparison mode: 0 = unsigned, 1 = two's-complement.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  sample value.
- valid  input  1  data_in carries a sample this cycle.
- go  input  1  open a new frame.
- finish  input  1  close the current frame.
- min_out  output  WIDTH  running/held minimum.
- max_out  output  WIDTH  running/held maximum.
- range_out  output  WIDTH  max_out - min_out, unsigned.
- count_out  output  CNT_W  accepted samples in the frame, saturating.
- busy  output  1  state == RUN.
- done  output  1  state == DONE.
- error  output  1  state == ERROR.
- cnt_sat  output  1  count saturated this frame (sticky until the next frame opens).

Behaviour:
- Reset (asynchronous): state = IDLE; min/max/count/cnt_sat = 0; all outputs 0.
- States: IDLE, RUN, DONE, ERROR. One next-state block; state updates on the rising clock edge.
- Start condition: go && !finish while in IDLE, DONE or ERROR.
  - State goes to RUN.
  - count and cnt_sat clear.
  - If valid is also high, data_in is accepted as the frame's first sample.
- Sample acceptance: in RUN, when valid && !finish. The sample on a finish cycle is never accepted.
- First accepted sample (count == 0): min = max = data_in. No compare against stale values.
- Later samples:
  - min loads data_in if data_in < min;
  - max loads data_in if data_in > max;
  - both use signed compare when SIGNED = 1.
- Sample with valid low: no change.
- count:
  - +1 per accepted sample;
  - at all-ones it holds, and cnt_sat sets.
- range_out: combinational max - min, modulo 2^WIDTH, always non-negative. It fits in WIDTH bits in both modes.
- Latency: sample accepted at edge k is visible on min_out/max_out/range_out/count_out after edge k. Registered outputs, one-cycle latency.
- RUN transitions:
  - finish with count > 0 → DONE;
  - finish with count == 0 → ERROR (empty frame);
  - go is ignored in RUN (no restart);
  - go && finish → finish wins.
- DONE transitions:
  - finish still high → stay in DONE;
  - !finish && go → RUN (new frame as above);
  - !finish && !go → IDLE.
  - Results are held in DONE and IDLE.
- IDLE transitions:
  - finish (with or without go) → ERROR;
  - start condition → RUN;
  - otherwise stay.
- ERROR:
  - Entering ERROR clears min/max/count/cnt_sat to 0.
  - Stays in ERROR until the start condition.
  - go && finish in ERROR stays in ERROR.
- Status outputs: busy/done/error are decoded from the registered state, so they are glitch-free and mutually exclusive.
- Reset mid-frame: immediate return to IDLE with all results zero. No partial result survives.

Test Plan:
- Unsigned basic frame (WIDTH=10):
  - Stimulus: go+valid with 300, then valid samples 512, 7, 1023, 100, then finish.
  - Required: min 7, max 1023, range 1016, count 5, done=1.
  - Then drop finish: IDLE with values held.
- First-sample seeding and valid gating:
  - Stimulus: go with valid=0; then valid 50; invalid cycle with data 0; valid 60.
  - Required: min 50, max 60, range 10, count 2.
- Signed mode (SIGNED=1, WIDTH=10):
  - Stimulus: samples -512 (10'h200), 511, -1.
  - Required: min 10'h200, max 10'h1FF, range 1023.
- Empty frame and error recovery:
  - Stimulus: go, then finish with no valid samples.
  - Required: error=1, all results 0.
  - Then go+valid 5: RUN, error=0, min = max = 5.
- IDLE misuse:
  - Stimulus: finish in IDLE, then go && finish.
  - Required: ERROR and remains in ERROR.
  - Then go alone: RUN.
- Saturation and reset:
  - Stimulus (CNT_W=3): 9 samples.
  - Required: count 7, cnt_sat=1.
  - Then assert reset mid-frame asynchronously: all outputs 0 before the next clock edge; state IDLE.
